mult_acc_pipe: RTL

Parametrised, pipelined multiply-accumulate block; successor of the fixed 20x18 unsigned multiplier timing-characterisation wrapper.
- Adds configurable operand/accumulator width and product pipeline depth.
- Adds per-sample signed/unsigned mode, accumulate/load control, a valid handshake and overflow detection.
- Sits between registered datapath sources and downstream sinks; used both in DSP datapaths and as a timing-characterisation target at several pipeline depths.

---
 rtl/mult_acc_pkg.sv | 28 ++
 rtl/mult_acc_delay.sv | 54 +++++
 rtl/mult_acc_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the pipelined multiply-accumulate block.
// Contents:
//   MAX_PIPE_STAGES  - largest legal product pipeline depth
//   MODE_UNSIGNED / MODE_SIGNED - operand interpretation encodings
//   stage_ctrl_t     - per-sample control fields carried down the product pipe
//   mult_acc_latency - in_valid to out_valid latency in cycles
package mult_acc_pkg;

    localparam int unsigned MAX_PIPE_STAGES = 4;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Control half of the pipe-stage bundle. The product rides alongside it in
    // the same delay-line word, and the valid bit has its own reset-capable
    // lane in the delay line, because the product width is a parameter of the
    // block.
    typedef struct packed {
        logic signed_mode;
        logic acc_en;
    } stage_ctrl_t;

    // Input register + product stages + accumulator register.
    function automatic int unsigned mult_acc_latency(input int unsigned pipe_stages);
        return pipe_stages + 32'd2;
    endfunction

endpackage

// File: rtl/mult_acc_delay.sv
// Register chain of configurable width and depth with a separate valid lane.
// Only the valid lane is reset (synchronous, active-low). DEPTH == 0 is a
// combinational pass-through.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   in_valid, in_data   - sample entering the chain
//   out_valid, out_data - sample leaving the chain DEPTH cycles later
module mult_acc_delay #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        // Clock and reset are not needed when there are no registers.
        logic unused_ok;
        assign unused_ok = ^{clk, reset};
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_regs
        logic [DEPTH-1:0] vld_q;
        logic [WIDTH-1:0] data_q [DEPTH];

        // Valid lane: cleared on reset so in-flight samples are dropped.
        always_ff @(posedge clk) begin
            if (!reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        // Data lane: free-running, meaningless while its valid is low.
        always_ff @(posedge clk) begin
            data_q[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        assign out_valid = vld_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with sticky overflow.
// Pipeline: input register -> product (PIPE_STAGES registers) -> accumulator.
// Latency in_valid -> out_valid is PIPE_STAGES+2 cycles, one sample per cycle.
// Build option: define MULT_ACC_SAT_EN to saturate the accumulator on overflow
// instead of wrapping (overflow flag behaves the same either way).
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   in_valid     - a/b/signed_mode/acc_en are sampled this cycle
//   a, b         - operands
//   signed_mode  - 1: two's-complement operands, 0: unsigned
//   acc_en       - 1: accumulate, 0: load product and start a new chain
//   out_valid    - z/overflow updated this cycle
//   z            - accumulator value
//   overflow     - sticky overflow flag for the current chain
module mult_acc_pipe
    import mult_acc_pkg::*;
#(
    parameter int unsigned A_WIDTH     = 20,
    parameter int unsigned B_WIDTH     = 18,
    parameter int unsigned ACC_WIDTH   = 48,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] z,
    output logic                 overflow
);

    localparam int unsigned PROD_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int unsigned CTRL_WIDTH   = $bits(stage_ctrl_t);
    localparam int unsigned BUNDLE_WIDTH = CTRL_WIDTH + ACC_WIDTH;

    // Parameter legality.
    if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc_width
        $error("mult_acc_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_pipe_stages
        $error("mult_acc_pipe: PIPE_STAGES out of range 0..4");
    end

    // Stage 0: input register.
    logic               in_vld_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               sm_q;
    logic               en_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_vld_q <= 1'b0;
        end else begin
            in_vld_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        a_q  <= a;
        b_q  <= b;
        sm_q <= signed_mode;
        en_q <= acc_en;
    end

    // Product: extending both operands to the product width first makes a
    // plain modular multiply produce the exact signed or unsigned product.
    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]  prod_ext;

    always_comb begin
        a_ext    = (sm_q == MODE_SIGNED) ? PROD_WIDTH'($signed(a_q)) : PROD_WIDTH'(a_q);
        b_ext    = (sm_q == MODE_SIGNED) ? PROD_WIDTH'($signed(b_q)) : PROD_WIDTH'(b_q);
        prod     = a_ext * b_ext;
        prod_ext = (sm_q == MODE_SIGNED) ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    end

    // Product delay line carrying control and product together.
    stage_ctrl_t             s0_ctrl;
    logic [BUNDLE_WIDTH-1:0] s0_bundle;
    logic                    d_vld;
    logic [BUNDLE_WIDTH-1:0] d_bundle;
    stage_ctrl_t             d_ctrl;
    logic [ACC_WIDTH-1:0]    d_prod;

    assign s0_ctrl   = '{signed_mode: sm_q, acc_en: en_q};
    assign s0_bundle = {s0_ctrl, prod_ext};

    mult_acc_delay #(
        .WIDTH (BUNDLE_WIDTH),
        .DEPTH (PIPE_STAGES)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_vld_q),
        .in_data   (s0_bundle),
        .out_valid (d_vld),
        .out_data  (d_bundle)
    );

    assign d_ctrl = stage_ctrl_t'(d_bundle[BUNDLE_WIDTH-1:ACC_WIDTH]);
    assign d_prod = d_bundle[ACC_WIDTH-1:0];

    // Accumulator stage.
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 out_vld_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 add_ovf;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        sum   = {1'b0, acc_q} + {1'b0, d_prod};
        // The arriving sample's mode decides how the add is judged.
        if (d_ctrl.signed_mode == MODE_SIGNED) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == d_prod[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != d_prod[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum[ACC_WIDTH];
        end

        if (d_vld) begin
            if (!d_ctrl.acc_en) begin
                acc_d = d_prod;
                ovf_d = 1'b0;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
`ifdef MULT_ACC_SAT_EN
                // Signed overflow only happens when both addends share the
                // product's sign, so that sign picks the clamp direction.
                if (add_ovf) begin
                    if (d_ctrl.signed_mode == MODE_SIGNED) begin
                        acc_d = d_prod[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                    end else begin
                        acc_d = '1;
                    end
                end
`endif
                ovf_d = ovf_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_vld_q <= d_vld;
        end
    end

    assign z         = acc_q;
    assign overflow  = ovf_q;
    assign out_valid = out_vld_q;

endmodule
